// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle MIPS control unit.
// Covers opcodes, functs, FSM states, ALU codes, datapath selects and trap causes.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_JUMP   = 4'd12,
    ST_TRAP   = 4'd13
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_TRAP   = 2'b11;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // States that hold a memory request until mem_ready.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

  // Final states of an instruction that completes normally.
  function automatic logic is_retire_state(input state_t s);
    return (s == ST_MEMWB) || (s == ST_MEMWR) || (s == ST_ALUWB) ||
           (s == ST_BRANCH) || (s == ST_ADDIWB) || (s == ST_JUMP);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: R-type funct field to ALU control code, flagging unsupported functs.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       illegal
);

  // Funct lookup; unknown codes report illegal and fall back to add.
  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM with memory wait states, timeout and trap path.
// Optional instr_retired/stall_cycles counters are built when MC_CTRL_PERF_EN is defined.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned TIMEOUT_W      = 4,
  parameter int unsigned CNT_W          = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       branch,
  output logic       branch_ne,
  output logic       trap,
  output logic [1:0] trap_cause
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_retired,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  localparam logic [TIMEOUT_W:0] TIMEOUT_LIMIT = (TIMEOUT_W+1)'(TIMEOUT_CYCLES);

  state_t               state;
  state_t               next_state;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [TIMEOUT_W:0]   wait_inc;
  logic                 in_wait;
  logic                 timeout_hit;
  logic [2:0]           funct_alu;
  logic                 funct_illegal;

  mc_alu_decoder u_alu_decoder (
    .funct       (funct),
    .alu_control (funct_alu),
    .illegal     (funct_illegal)
  );

  assign in_wait  = is_wait_state(state);
  assign wait_inc = {1'b0, wait_cnt} + {{TIMEOUT_W{1'b0}}, 1'b1};
  // mem_ready takes priority over a timeout reached in the same cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && in_wait && !mem_ready &&
                       (wait_inc == TIMEOUT_LIMIT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: next_state = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)        next_state = ST_DECODE;
        else if (timeout_hit) next_state = ST_TRAP;
        else                  next_state = ST_FETCH;
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:       next_state = ST_EXEC;
          OP_LW, OP_SW:   next_state = ST_MEMADR;
          OP_BEQ, OP_BNE: next_state = ST_BRANCH;
          OP_ADDI:        next_state = ST_ADDIEX;
          OP_J:           next_state = ST_JUMP;
          default:        next_state = ST_TRAP;
        endcase
      end
      ST_MEMADR: begin
        if (opcode == OP_SW) next_state = ST_MEMWR;
        else                 next_state = ST_MEMRD;
      end
      ST_MEMRD: begin
        if (mem_ready)        next_state = ST_MEMWB;
        else if (timeout_hit) next_state = ST_TRAP;
        else                  next_state = ST_MEMRD;
      end
      ST_MEMWR: begin
        if (mem_ready)        next_state = ST_FETCH;
        else if (timeout_hit) next_state = ST_TRAP;
        else                  next_state = ST_MEMWR;
      end
      ST_EXEC: begin
        if (funct_illegal) next_state = ST_TRAP;
        else               next_state = ST_ALUWB;
      end
      ST_ADDIEX: next_state = ST_ADDIWB;
      ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_ADDIWB, ST_JUMP, ST_TRAP: next_state = ST_FETCH;
      default: next_state = ST_IDLE;
    endcase
  end

  // Moore outputs; FETCH additionally qualifies IR/PC writes with mem_ready.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRC_B_REG;
    alu_control = 3'b000;
    pc_src      = PC_SRC_ALU;
    pc_write    = 1'b0;
    branch      = 1'b0;
    branch_ne   = 1'b0;
    trap        = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = SRC_B_FOUR;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b   = SRC_B_IMM_SH;
        alu_control = ALU_ADD;
      end
      ST_MEMADR, ST_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRC_B_IMM;
        alu_control = ALU_ADD;
      end
      ST_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      ST_MEMWR: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = 1'b1;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
      end
      ST_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = PC_SRC_ALUOUT;
        branch      = (opcode == OP_BEQ);
        branch_ne   = (opcode == OP_BNE);
      end
      ST_ADDIWB: reg_write = 1'b1;
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
      end
      ST_TRAP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_TRAP;
        trap     = 1'b1;
      end
      default: mem_req = 1'b0;
    endcase
  end

  // Wait-state counter: restarts whenever a wait state is entered or memory responds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if ((next_state != state) || mem_ready) begin
      wait_cnt <= '0;
    end else if (in_wait) begin
      wait_cnt <= wait_cnt + TIMEOUT_W'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Trap cause latched on entry to TRAP and held until the next trap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_cause <= CAUSE_NONE;
    end else if ((next_state == ST_TRAP) && (state != ST_TRAP)) begin
      trap_cause <= in_wait ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
    end else begin
      trap_cause <= trap_cause;
    end
  end

`ifdef MC_CTRL_PERF_EN
  // Retired-instruction and memory-stall counters, both free-running with wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_retired <= '0;
      stall_cycles  <= '0;
    end else begin
      if ((next_state == ST_FETCH) && is_retire_state(state)) begin
        instr_retired <= instr_retired + CNT_W'(1);
      end else begin
        instr_retired <= instr_retired;
      end
      if (in_wait && !mem_ready) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end else begin
        stall_cycles <= stall_cycles;
      end
    end
  end
`else
  // Counter width only matters when the performance counters are built.
  if (CNT_W == 0) begin : g_no_perf
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed plus randomized instruction stream against a per-instruction
// reference model (latency, write/branch/trap effects, counters).
module tb_mc_controller;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src, trap_cause;
  logic [2:0] alu_control;
  logic       pc_write, branch, branch_ne, trap;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_retired, stall_cycles;
`endif

  mc_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .pc_src(pc_src), .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne),
    .trap(trap), .trap_cause(trap_cause)
`ifdef MC_CTRL_PERF_EN
    , .instr_retired(instr_retired), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_ret = 0;
  int exp_stall = 0;
  logic [1:0] exp_cause = 2'b00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] all_outs();
    return {mem_req, mem_we, i_or_d, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
            alu_src_b, alu_control, pc_src, pc_write, branch, branch_ne, trap, trap_cause};
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // kind: 0 R legal, 1 R bad funct, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 ADDI, 7 J, 8 bad opcode.
  // Entered just after a negedge with the DUT in the first cycle of FETCH.
  task automatic run_instr(input string name, input int kind, input logic [5:0] op,
                           input logic [5:0] fn, input int fw, input int mw);
    bit fetch_to, mem_op, mem_to, trapped, seen, done, rdy;
    int e_cycles, n, fl, ml;
    int o_rw, o_m2r, o_rdst, o_commit, o_br, o_bne, o_pcw, o_irw, o_trap, o_bad;
    logic [1:0] o_cause;
    fetch_to = (fw >= TO);
    mem_op   = (kind == 2) || (kind == 3);
    mem_to   = !fetch_to && mem_op && (mw >= TO);
    trapped  = fetch_to || mem_to || (kind == 1) || (kind == 8);
    case (kind)
      2:       e_cycles = 5;
      4, 5, 7, 8: e_cycles = 3;
      default: e_cycles = 4;
    endcase
    if (fetch_to)      e_cycles = TO + 1;
    else if (mem_to)   e_cycles = fw + TO + 4;
    else if (mem_op)   e_cycles = e_cycles + fw + mw;
    else               e_cycles = e_cycles + fw;
    if (trapped) exp_cause = (fetch_to || mem_to) ? 2'b10 : 2'b01;
    if (!trapped) exp_ret++;
    exp_stall += fetch_to ? TO : (fw + (mem_op ? imin(mw, TO) : 0));

    opcode = op; funct = fn;
    fl = fw; ml = mw; n = 0; seen = 0; done = 0;
    o_rw = 0; o_m2r = 0; o_rdst = 0; o_commit = 0; o_br = 0; o_bne = 0;
    o_pcw = 0; o_irw = 0; o_trap = 0; o_bad = 0; o_cause = 2'b00;
    for (int c = 0; c < 200; c++) begin
      if (c != 0) @(negedge clk);
      if (seen && mem_req && !i_or_d) begin
        done = 1;
        break;
      end
      if (mem_req) begin
        if (!i_or_d) begin rdy = (fl == 0); if (fl > 0) fl--; end
        else begin rdy = (ml == 0); if (ml > 0) ml--; end
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      mem_ready = rdy;
      #1;
      n++;
      if (!(mem_req && !i_or_d)) seen = 1;
      if (mem_req && !i_or_d && (ir_write !== rdy || pc_write !== rdy)) o_bad++;
      if (mem_we && !(mem_req && i_or_d)) o_bad++;
      o_rw     += int'(reg_write);
      o_m2r    += int'(reg_write & mem_to_reg);
      o_rdst   += int'(reg_write & reg_dst);
      o_commit += int'(mem_we & mem_ready);
      o_br     += int'(branch);
      o_bne    += int'(branch_ne);
      o_pcw    += int'(pc_write);
      o_irw    += int'(ir_write);
      o_trap   += int'(trap);
      if (trap) begin
        o_cause = trap_cause;
        check({name, ".trap_pc_src"}, {pc_src, pc_write}, {2'b11, 1'b1});
      end
      if (branch || branch_ne)
        check({name, ".branch_sel"}, {pc_src, alu_control, alu_src_a, alu_src_b},
              {2'b01, 3'b110, 1'b1, 2'b00});
    end
    check({name, ".finished"}, done, 1'b1);
    check({name, ".cycles"}, n, e_cycles);
    check({name, ".ir_write"}, o_irw, fetch_to ? 0 : 1);
    check({name, ".pc_write"}, o_pcw, (fetch_to ? 0 : 1) + (trapped ? 1 : 0) +
                                      ((kind == 7 && !fetch_to) ? 1 : 0));
    check({name, ".reg_write"}, o_rw, (!trapped && (kind == 0 || kind == 2 || kind == 6)) ? 1 : 0);
    check({name, ".mem_to_reg"}, o_m2r, (!trapped && kind == 2) ? 1 : 0);
    check({name, ".reg_dst"}, o_rdst, (!trapped && kind == 0) ? 1 : 0);
    check({name, ".mem_commit"}, o_commit, (!trapped && kind == 3) ? 1 : 0);
    check({name, ".branch"}, {o_br, o_bne}, {(!fetch_to && kind == 4) ? 1 : 0,
                                             (!fetch_to && kind == 5) ? 1 : 0});
    check({name, ".trap"}, o_trap, trapped ? 1 : 0);
    if (trapped) check({name, ".trap_cause_in_trap"}, o_cause, exp_cause);
    check({name, ".trap_cause_held"}, trap_cause, exp_cause);
    check({name, ".protocol"}, o_bad, 0);
`ifdef MC_CTRL_PERF_EN
    check({name, ".instr_retired"}, instr_retired, exp_ret);
    check({name, ".stall_cycles"}, stall_cycles, exp_stall);
`endif
  endtask

  logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [5:0] bad_op   [4] = '{6'b111111, 6'b000011, 6'b001101, 6'b100000};
  logic [5:0] kind_op  [9] = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100,
                               6'b000101, 6'b001000, 6'b000010, 6'b111111};

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 11) return r % 4;
    else if (r < 13) return 14;
    else if (r < 15) return 15;
    else return 20;
  endfunction

  initial begin
    int kind, fw, mw;
    logic [5:0] op, fn;
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'b000000; funct = 6'b000000;
    repeat (2) @(negedge clk);
    #1;
    check("reset.outputs", all_outs(), 21'd0);
`ifdef MC_CTRL_PERF_EN
    check("reset.counters", {instr_retired, stall_cycles}, 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle.outputs", all_outs(), 21'd0);
    @(negedge clk);
    #1;
    check("fetch.selects", {mem_req, i_or_d, alu_src_a, alu_src_b, alu_control, pc_src},
          {1'b1, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00});

    // Directed steps (ordered to follow the plan, then boundaries).
    run_instr("lw_ready",     2, 6'b100011, 6'b000000, 0, 0);
    run_instr("add_fetch3",   0, 6'b000000, 6'b100000, 3, 0);
    run_instr("bne",          5, 6'b000101, 6'b000000, 0, 0);
    run_instr("beq",          4, 6'b000100, 6'b000000, 1, 0);
    run_instr("bad_opcode",   8, 6'b111111, 6'b000000, 0, 0);
    run_instr("sw_timeout",   3, 6'b101011, 6'b000000, 0, 40);
    run_instr("sw_to_exact",  3, 6'b101011, 6'b000000, 0, 15);
    run_instr("lw_wait14",    2, 6'b100011, 6'b000000, 0, 14);
    run_instr("fetch_timeout",0, 6'b000000, 6'b100010, 15, 0);
    run_instr("bad_funct",    1, 6'b000000, 6'b000000, 0, 0);
    run_instr("addi",         6, 6'b001000, 6'b000000, 2, 0);
    run_instr("jump",         7, 6'b000010, 6'b000000, 0, 0);
    run_instr("fetch_wait14", 0, 6'b000000, 6'b101010, 14, 0);
    run_instr("sw_wait2",     3, 6'b101011, 6'b000000, 1, 2);

    // Randomized instruction stream.
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 8));
      op = kind_op[kind];
      fn = 6'($urandom);
      if (kind == 0) fn = legal_fn[$urandom_range(0, 4)];
      if (kind == 1 && (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                        fn == 6'b100101 || fn == 6'b101010)) fn = 6'b111111;
      if (kind == 8) op = bad_op[$urandom_range(0, 3)];
      fw = rand_wait();
      mw = rand_wait();
      run_instr($sformatf("rnd%0d_k%0d", i, kind), kind, op, fn, fw, mw);
    end

    // Reset in the middle of a MEMRD wait.
    opcode = 6'b100011;
    mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("memrd.waiting", {mem_req, i_or_d, mem_we}, 3'b110);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_mid.outputs", all_outs(), 21'd0);
`ifdef MC_CTRL_PERF_EN
    check("reset_mid.counters", {instr_retired, stall_cycles}, 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_mid.idle", all_outs(), 21'd0);
    @(negedge clk);
    #1;
    check("reset_mid.fetch", {mem_req, i_or_d, trap_cause}, {1'b1, 1'b0, 2'b00});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Parametrised multicycle MIPS control unit, successor to the fixed single-speed controller. Adds a memory request/ready handshake with wait states, a bounded wait timeout, BNE/ADDI/J support and a trap path for illegal instructions and memory timeouts. Sits between the instruction register and the multicycle datapath inside the processor top; the datapath forms PC enable from `pc_write | (branch & zero) | (branch_ne & ~zero)`.

## Interface
- `TIMEOUT_CYCLES`, 15: wait-state limit per memory access; 0 disables the timeout.
- `TIMEOUT_W`, 4: width of the wait counter; must hold `TIMEOUT_CYCLES`.
- `CNT_W`, 32: width of the performance counters.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high
- `opcode`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`, `mem_we`  out  1  memory access request, write qualifier
- `i_or_d`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1  datapath selects/enables
- `alu_src_b`  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2
- `alu_control`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- `pc_src`  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 trap vector
- `pc_write`, `branch`, `branch_ne`  out  1  PC update controls
- `trap`  out  1  one-cycle trap pulse
- `trap_cause`  out  2  01 illegal instruction, 10 memory timeout; held until next trap
- `instr_retired`, `stall_cycles`  out  CNT_W  present only with `MC_CTRL_PERF_EN`

## Operation
- Moore FSM. States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP.
- IDLE: all outputs 0. Entered on reset, left for FETCH on the next clock.
- FETCH: `mem_req`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, add, `pc_src`=00. `ir_write` and `pc_write` equal `mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, add (branch target). Next state by opcode:
  - 000000 → EXEC
  - 100011/101011 → MEMADR
  - 000100/000101 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - any other opcode → TRAP (cause 01)
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, add. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD/MEMWR: `mem_req`=1, `i_or_d`=1, `mem_we`=1 in MEMWR only. Wait until `mem_ready`. MEMRD then goes to MEMWB; MEMWR goes to FETCH.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, funct-decoded op. An unknown funct goes to TRAP (cause 01) instead of ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_src`=01. `branch`=1 for BEQ, `branch_ne`=1 for BNE.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, add. ADDIWB: `reg_write`=1, `reg_dst`=0.
- JUMP: `pc_write`=1, `pc_src`=10.
- TRAP: `pc_write`=1, `pc_src`=11, `trap`=1. `trap_cause` is registered on entry to TRAP. Next state is FETCH.
- MEMWB, ALUWB, BRANCH, ADDIWB and JUMP return to FETCH.
- Wait counter:
  - Clears on entry to any wait state (FETCH, MEMRD, MEMWR) and on `mem_ready`.
  - Increments every cycle spent waiting without `mem_ready`.
  - When it reaches `TIMEOUT_CYCLES` (nonzero) without `mem_ready`, the FSM goes to TRAP with cause 10 and drops `mem_req`. MEMWR timeout: no write is committed.
- If `mem_ready` is asserted in the same cycle the timeout is reached, `mem_ready` wins.

## Timing
- Reset: state IDLE; all outputs 0; `trap_cause`=00; counters 0. Reset mid-access drops `mem_req` immediately (async).
- Zero wait-state latencies: R-type 4 cycles, LW 5, SW 4, BEQ/BNE 3, ADDI 4, J 3, trap entry 3 (FETCH, DECODE, TRAP).
- Each `mem_ready`-low cycle during a wait adds one cycle.
- `mem_req` is held stable with constant address selects until `mem_ready` is sampled high.

## Configuration
- `MC_CTRL_PERF_EN` defined:
  - `instr_retired` increments on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. TRAP does not count.
  - `stall_cycles` increments each wait-state cycle with `mem_ready` low.
  - Both counters wrap modulo 2^CNT_W.
- Undefined: both ports and their counters are absent.

## Structure
- Package `mc_ctrl_pkg`:
  - opcode and funct constants
  - state enum
  - ALU control codes
  - `pc_src` and `alu_src_b` encodings
  - trap cause codes
- Sub-module `mc_alu_decoder`: combinational funct → `alu_control` plus `illegal` flag. Instantiated once.

## Test plan
- Reset, then LW with `mem_ready` tied high → states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB; `reg_write`=1 and `mem_to_reg`=1 only in MEMWB.
- FETCH with `mem_ready` low for 3 cycles → `ir_write`/`pc_write` stay 0 until the 4th cycle; `stall_cycles`=3 (PERF_EN).
- BNE (000101) → `branch_ne`=1, `branch`=0, `pc_src`=01, `alu_control`=110 in BRANCH.
- Opcode 111111 → TRAP after DECODE; `trap` pulses 1 cycle, `trap_cause`=01, `pc_src`=11.
- MEMWR with `mem_ready` never high, TIMEOUT_CYCLES=15 → TRAP after 15 wait cycles, `trap_cause`=10, `mem_we` deasserted.
- Assert `reset` mid-MEMRD wait → all outputs 0 at once; after release, IDLE then FETCH; counters cleared.
